// File: rtl/door_sched_pkg.sv
// Shared types, default timing constants and sizing helpers for the door access scheduler.
package door_sched_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, OPEN, DENY} state_t;

  localparam int unsigned DEF_N_DOORS     = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 32;
  localparam int unsigned DEF_OPEN_CYC    = 16;
  localparam int unsigned DEF_DENY_CYC    = 8;
  localparam int unsigned DEF_MAX_FAIL    = 3;
  localparam int unsigned DEF_LOCKOUT_CYC = 64;

  // Bits needed to index v items; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/door_lock_tracker.sv
// Per-door invalid-card counter and lockout timer; locked while the timer is non-zero.
module door_lock_tracker
  import door_sched_pkg::*;
#(
  parameter int unsigned MAX_FAIL    = DEF_MAX_FAIL,
  parameter int unsigned LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic deny_pulse,
  input  logic grant_pulse,
  output logic locked
);

  localparam int unsigned FW = clog2(MAX_FAIL);
  localparam int unsigned LW = clog2(LOCKOUT_CYC + 1);

  logic [FW-1:0] fail_cnt;
  logic [LW-1:0] lock_timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      fail_cnt   <= '0;
      lock_timer <= '0;
    end else begin
      if (lock_timer != '0) lock_timer <= lock_timer - 1'b1;
      if (deny_pulse) begin
        if (fail_cnt == FW'(MAX_FAIL - 1)) begin
          fail_cnt   <= '0;
          lock_timer <= LW'(LOCKOUT_CYC);
        end else begin
          fail_cnt <= fail_cnt + 1'b1;
        end
      end else if (grant_pulse) begin
        fail_cnt <= '0;
      end
    end
  end

  assign locked = (lock_timer != '0);

endmodule

// File: rtl/door_access_scheduler.sv
// Round-robin sharing of one card reader between N_DOORS doors with open/deny/timeout sequencing.
// Lockout after repeated invalid cards is enabled by defining DOOR_SCHED_LOCKOUT_EN.
module door_access_scheduler
  import door_sched_pkg::*;
#(
  parameter int unsigned N_DOORS     = DEF_N_DOORS,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned OPEN_CYC    = DEF_OPEN_CYC,
  parameter int unsigned DENY_CYC    = DEF_DENY_CYC,
  parameter int unsigned MAX_FAIL    = DEF_MAX_FAIL,
  parameter int unsigned LOCKOUT_CYC = DEF_LOCKOUT_CYC,
  localparam int unsigned SEL_W      = clog2(N_DOORS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_DOORS-1:0] sensor_entrance,
  input  logic               card_present,
  input  logic               card_valid,
  output logic               reader_en,
  output logic [SEL_W-1:0]   reader_sel,
  output logic [N_DOORS-1:0] door_open,
  output logic [N_DOORS-1:0] green_led,
  output logic [N_DOORS-1:0] red_led,
  output logic [N_DOORS-1:0] yellow_led,
  output logic               alarm,
  output logic               busy
);

  localparam int unsigned TW = clog2(max3(TIMEOUT_CYC, OPEN_CYC, DENY_CYC));
  localparam logic [N_DOORS-1:0] ONE = {{(N_DOORS-1){1'b0}}, 1'b1};

  state_t             state;
  logic [SEL_W-1:0]   rr_ptr, pick, cand, nxt_ptr;
  logic [TW-1:0]      timer;
  logic [N_DOORS-1:0] locked, elig, sel_mask, show_mask_n;
  logic               any_elig, card_ok, card_bad, done, wait_drop;
  logic               show_n, deny_n, lock_arm;

`ifdef DOOR_SCHED_LOCKOUT_EN
  assign lock_arm = 1'b1;
`else
  assign lock_arm = 1'b0;
`endif

  // With lock_arm low the trackers never see a pulse, so locked stays 0.
  for (genvar g = 0; g < N_DOORS; g++) begin : g_lock
    door_lock_tracker #(
      .MAX_FAIL   (MAX_FAIL),
      .LOCKOUT_CYC(LOCKOUT_CYC)
    ) u_trk (
      .clk        (clk),
      .reset      (reset),
      .deny_pulse (lock_arm & (state == WAIT) & card_bad & (reader_sel == SEL_W'(g))),
      .grant_pulse(lock_arm & (state == WAIT) & card_ok & (reader_sel == SEL_W'(g))),
      .locked     (locked[g])
    );
  end

  assign elig      = sensor_entrance & ~locked;
  assign card_ok   = card_present & card_valid;
  assign card_bad  = card_present & ~card_valid;
  assign done      = (timer == '0);
  assign wait_drop = ~sensor_entrance[reader_sel] | done;
  assign sel_mask  = ONE << reader_sel;
  assign nxt_ptr   = (reader_sel == SEL_W'(N_DOORS - 1)) ? '0 : reader_sel + 1'b1;

  always_comb begin
    any_elig = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int unsigned k = 0; k < N_DOORS; k++) begin
      cand = SEL_W'((32'(rr_ptr) + k) % N_DOORS);
      if (!any_elig && elig[cand]) begin
        any_elig = 1'b1;
        pick     = cand;
      end
    end
  end

  // Which door the FSM shows after this edge, and whether it shows red; drives busy/red/lock overlay.
  always_comb begin
    show_n = 1'b0;
    deny_n = 1'b0;
    case (state)
      IDLE: show_n = any_elig;
      WAIT: begin
        show_n = card_present | ~wait_drop;
        deny_n = card_bad;
      end
      OPEN: show_n = ~done;
      DENY: begin
        show_n = ~done;
        deny_n = ~done;
      end
      default: ;
    endcase
  end

  assign show_mask_n = show_n ? ((state == IDLE) ? (ONE << pick) : sel_mask) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      reader_sel <= '0;
      timer      <= '0;
      reader_en  <= 1'b0;
      yellow_led <= '0;
      green_led  <= '0;
      door_open  <= '0;
    end else begin
      case (state)
        IDLE: if (any_elig) begin
          state      <= WAIT;
          reader_sel <= pick;
          timer      <= TW'(TIMEOUT_CYC - 1);
          reader_en  <= 1'b1;
          yellow_led <= ONE << pick;
        end
        WAIT: begin
          if (card_ok) begin
            state      <= OPEN;
            timer      <= TW'(OPEN_CYC - 1);
            green_led  <= sel_mask;
            door_open  <= sel_mask;
          end else if (card_bad) begin
            state      <= DENY;
            timer      <= TW'(DENY_CYC - 1);
          end else if (wait_drop) begin
            state      <= IDLE;
          end else begin
            timer      <= timer - 1'b1;
          end
          if (card_present || wait_drop) begin
            reader_en  <= 1'b0;
            yellow_led <= '0;
            rr_ptr     <= nxt_ptr;
          end
        end
        OPEN, DENY: begin
          if (done) begin
            state     <= IDLE;
            green_led <= '0;
            door_open <= '0;
            rr_ptr    <= nxt_ptr;
          end else begin
            timer     <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      red_led <= '0;
      alarm   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      red_led <= (locked & ~show_mask_n) | (deny_n ? show_mask_n : '0);
      alarm   <= lock_arm & (|locked);
      busy    <= show_n;
    end
  end

endmodule

// File: tb/tb_door_access_scheduler.sv
// Self-checking bench for door_access_scheduler: directed scenarios plus random traffic against a cycle model.
module tb_door_access_scheduler;

  localparam int N  = 4;
  localparam int TO = 32;
  localparam int OC = 16;
  localparam int DC = 8;
  localparam int MF = 3;
  localparam int LC = 64;
`ifdef DOOR_SCHED_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] sensor = '0;
  logic         cp = 1'b0, cv = 1'b0;
  logic         reader_en, alarm, busy;
  logic [1:0]   reader_sel;
  logic [N-1:0] door_open, green_led, red_led, yellow_led;

  int checks = 0;
  int failures = 0;

  // Reference model: door currently served (-1 none), phase 0=waiting 1=open 2=denied,
  // cycles left in the phase, next round-robin start, per-door fail counts and lock cycles left.
  int m_door, m_phase, m_left, m_rr;
  int m_fail[N];
  int m_lock[N];
  logic         e_en, e_alarm, e_busy;
  logic [1:0]   e_sel;
  logic [N-1:0] e_open, e_green, e_red, e_yellow;

  door_access_scheduler #(
    .N_DOORS(N), .TIMEOUT_CYC(TO), .OPEN_CYC(OC), .DENY_CYC(DC),
    .MAX_FAIL(MF), .LOCKOUT_CYC(LC)
  ) dut (
    .clk(clk), .reset(reset), .sensor_entrance(sensor),
    .card_present(cp), .card_valid(cv),
    .reader_en(reader_en), .reader_sel(reader_sel),
    .door_open(door_open), .green_led(green_led), .red_led(red_led),
    .yellow_led(yellow_led), .alarm(alarm), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic void model_step();
    logic [N-1:0] lk, shown;
    bit found;
    if (reset) begin
      m_door = -1; m_phase = 0; m_left = 0; m_rr = 0;
      for (int j = 0; j < N; j++) begin m_fail[j] = 0; m_lock[j] = 0; end
      e_en = 0; e_sel = 0; e_alarm = 0; e_busy = 0;
      e_open = '0; e_green = '0; e_red = '0; e_yellow = '0;
      return;
    end
    lk = '0;
    for (int j = 0; j < N; j++) begin
      if (LOCK_EN && m_lock[j] > 0) lk[j] = 1'b1;
      if (m_lock[j] > 0) m_lock[j]--;
    end
    if (m_door < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!found && sensor[j] && !lk[j]) begin
          found = 1; m_door = j; m_phase = 0; m_left = TO;
        end
      end
    end else if (m_phase == 0) begin
      if (cp && cv) begin
        m_phase = 1; m_left = OC; m_fail[m_door] = 0;
      end else if (cp) begin
        m_phase = 2; m_left = DC;
        if (LOCK_EN) begin
          m_fail[m_door]++;
          if (m_fail[m_door] == MF) begin m_fail[m_door] = 0; m_lock[m_door] = LC; end
        end
      end else if (!sensor[m_door] || m_left == 1) begin
        m_rr = (m_door + 1) % N; m_door = -1;
      end else begin
        m_left--;
      end
    end else if (m_left == 1) begin
      m_rr = (m_door + 1) % N; m_door = -1;
    end else begin
      m_left--;
    end
    shown = '0;
    if (m_door >= 0) shown[m_door] = 1'b1;
    e_busy   = (m_door >= 0);
    e_en     = e_busy && m_phase == 0;
    e_sel    = e_en ? 2'(m_door) : 2'b00;
    e_yellow = e_en ? shown : '0;
    e_open   = (e_busy && m_phase == 1) ? shown : '0;
    e_green  = e_open;
    e_red    = ((e_busy && m_phase == 2) ? shown : '0) | (lk & ~shown);
    e_alarm  = |lk;
  endfunction

  task automatic tick(input string tn);
    @(posedge clk);
    #1;
    model_step();
    checks++;
    if ({reader_en, (e_en ? reader_sel : 2'b00), alarm, busy} !== {e_en, e_sel, e_alarm, e_busy}) begin
      failures++;
      $display("FAIL %s ctrl{en,sel,alarm,busy} got=%b exp=%b", tn,
               {reader_en, reader_sel, alarm, busy}, {e_en, e_sel, e_alarm, e_busy});
    end
    checks++;
    if ({door_open, green_led, red_led, yellow_led} !== {e_open, e_green, e_red, e_yellow}) begin
      failures++;
      $display("FAIL %s leds{open,green,red,yellow} got=%h exp=%h", tn,
               {door_open, green_led, red_led, yellow_led}, {e_open, e_green, e_red, e_yellow});
    end
  endtask

  task automatic do_reset(input string tn, input int n);
    reset = 1'b1; sensor = '0; cp = 1'b0; cv = 1'b0;
    repeat (n) tick(tn);
    reset = 1'b0;
  endtask

  task automatic wait_grant(input string tn, output bit ok);
    int n;
    n = 0;
    while (reader_en !== 1'b1 && n < 200) begin
      tick(tn);
      n++;
    end
    ok = (reader_en === 1'b1);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s grant_wait got=no_grant exp=grant_within_200", tn);
    end
  endtask

  task automatic present_card(input string tn, input logic valid);
    cp = 1'b1; cv = valid;
    tick(tn);
    cp = 1'b0; cv = 1'b0;
  endtask

  task automatic test_reset();
    do_reset("reset", 10);
    checks++;
    if ({reader_en, busy, alarm, door_open, green_led, red_led, yellow_led} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {reader_en, busy, alarm, door_open,
               green_led, red_led, yellow_led});
    end
  endtask

  task automatic test_single_open();
    int n;
    sensor = 4'b0001;
    tick("open_grant");
    checks++;
    if ({reader_en, reader_sel, yellow_led} !== {1'b1, 2'd0, 4'b0001}) begin
      failures++;
      $display("FAIL open_grant got=%b exp=%b", {reader_en, reader_sel, yellow_led}, 7'b1000001);
    end
    present_card("open_card", 1'b1);
    n = 0;
    while (door_open === 4'b0001 && green_led === 4'b0001 && n < 100) begin
      n++;
      tick("open_hold");
    end
    checks++;
    if (n !== OC || busy !== 1'b0) begin
      failures++;
      $display("FAIL open_len got=%0d busy=%b exp=%0d busy=0", n, busy, OC);
    end
    sensor = '0;
    repeat (3) tick("open_tail");
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{0, 1, 3, 0};
    bit ok;
    do_reset("rr_reset", 2);
    sensor = 4'b1011;
    for (int g = 0; g < 4; g++) begin
      wait_grant("rr_wait", ok);
      checks++;
      if (32'(reader_sel) !== exp_order[g]) begin
        failures++;
        $display("FAIL rr_order[%0d] got=%0d exp=%0d", g, reader_sel, exp_order[g]);
      end
      present_card("rr_card", 1'b1);
    end
    sensor = '0;
    repeat (20) tick("rr_tail");
  endtask

`ifdef DOOR_SCHED_LOCKOUT_EN
  task automatic test_lockout();
    bit ok;
    int n;
    do_reset("lock_reset", 2);
    sensor = 4'b0010;
    for (int r = 0; r < 3; r++) begin
      wait_grant("lock_wait", ok);
      checks++;
      if (reader_sel !== 2'd1) begin
        failures++;
        $display("FAIL lock_sel got=%0d exp=1", reader_sel);
      end
      present_card("lock_card", 1'b0);
      n = 0;
      if (r < 2) begin
        while (red_led === 4'b0010 && n < 100) begin n++; tick("lock_deny"); end
        checks++;
        if (n !== DC) begin
          failures++;
          $display("FAIL deny_len got=%0d exp=%0d", n, DC);
        end
      end else begin
        while (n < 200 && (n == 0 || reader_en !== 1'b1)) begin
          tick("lock_hold");
          n++;
          if (n == 1) begin
            checks++;
            if (alarm !== 1'b1) begin
              failures++;
              $display("FAIL lock_alarm_on got=%b exp=1", alarm);
            end
          end
        end
        checks++;
        if (n !== LC + 1 || alarm !== 1'b0 || reader_sel !== 2'd1) begin
          failures++;
          $display("FAIL lock_release got=%0d alarm=%b sel=%0d exp=%0d alarm=0 sel=1",
                   n, alarm, reader_sel, LC + 1);
        end
      end
    end
    sensor = '0;
    repeat (40) tick("lock_tail");
  endtask
`else
  task automatic test_no_lockout();
    bit ok;
    do_reset("nolock_reset", 2);
    sensor = 4'b0001;
    for (int r = 0; r < 5; r++) begin
      wait_grant("nolock_wait", ok);
      checks++;
      if (reader_sel !== 2'd0 || alarm !== 1'b0) begin
        failures++;
        $display("FAIL nolock_grant[%0d] got=sel%0d alarm=%b exp=sel0 alarm=0", r, reader_sel, alarm);
      end
      present_card("nolock_card", 1'b0);
    end
    repeat (12) tick("nolock_tail");
    checks++;
    if (alarm !== 1'b0) begin
      failures++;
      $display("FAIL nolock_alarm got=%b exp=0", alarm);
    end
    sensor = '0;
    repeat (12) tick("nolock_idle");
  endtask
`endif

  task automatic test_abandon();
    bit ok;
    int n;
    do_reset("abandon_reset", 2);
    sensor = 4'b0100;
    wait_grant("abandon_wait", ok);
    n = 0;
    while (reader_en === 1'b1 && n < 100) begin n++; tick("abandon_hold"); end
    checks++;
    if (n !== TO) begin
      failures++;
      $display("FAIL abandon_len got=%0d exp=%0d", n, TO);
    end
    sensor = 4'b1111;
    tick("abandon_rr");
    checks++;
    if ({reader_en, reader_sel} !== 3'b111) begin
      failures++;
      $display("FAIL abandon_rr got=%b exp=111", {reader_en, reader_sel});
    end
    do_reset("drop_reset", 2);
    sensor = 4'b0100;
    wait_grant("drop_wait", ok);
    repeat (4) tick("drop_hold");
    sensor = '0;
    tick("drop_edge");
    checks++;
    if ({reader_en, busy} !== 2'b00) begin
      failures++;
      $display("FAIL drop_idle got=%b exp=00", {reader_en, busy});
    end
    sensor = 4'b1111;
    tick("drop_rr");
    checks++;
    if ({reader_en, reader_sel} !== 3'b111) begin
      failures++;
      $display("FAIL drop_rr got=%b exp=111", {reader_en, reader_sel});
    end
  endtask

  task automatic test_card_at_timeout();
    bit ok;
    do_reset("cto_reset", 2);
    sensor = 4'b0001;
    wait_grant("cto_wait", ok);
    repeat (TO - 1) tick("cto_hold");
    present_card("cto_card", 1'b1);
    checks++;
    if (door_open !== 4'b0001) begin
      failures++;
      $display("FAIL card_at_timeout got=%b exp=0001", door_open);
    end
    repeat (3) tick("cto_open");
    reset = 1'b1;
    tick("cto_abort");
    checks++;
    if ({reader_en, busy, alarm, door_open, green_led, red_led, yellow_led} !== '0) begin
      failures++;
      $display("FAIL reset_mid_open got=%b exp=0", {reader_en, busy, alarm, door_open,
               green_led, red_led, yellow_led});
    end
    reset = 1'b0;
    sensor = '0;
  endtask

  task automatic test_random();
    do_reset("rand_reset", 2);
    for (int i = 0; i < 3000; i++) begin
      if (i % 16 == 0) sensor = 4'($urandom);
      cp = ($urandom_range(0, 7) == 0);
      cv = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 599) == 0);
      tick("random");
    end
    reset = 1'b0; cp = 1'b0; cv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_open();
    test_round_robin();
`ifdef DOOR_SCHED_LOCKOUT_EN
    test_lockout();
`else
    test_no_lockout();
`endif
    test_abandon();
    test_card_at_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
